idecode: RTL and testbench
==========================

IDECODE -- requirements
Module: idecode

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port IF_ID_instr, input, 32, instruction from fetch latch.
REQ-004 SHALL have port IF_ID_npc, input, 32, PC+1 word address from fetch latch.
REQ-005 SHALL have port EX_MEM_PCSrc, input, 1, branch taken; flush request.
REQ-006 SHALL have port MEM_WB_RegWrite, input, 1, writeback enable.
REQ-007 SHALL have port MEM_WB_WriteReg, input, 5, writeback register index.
REQ-008 SHALL have port MEM_WB_WriteData, input, 32, writeback data.
REQ-009 SHALL have port ID_stall, output, 1, load-use hazard; fetch holds PC and IF/ID latch.
REQ-010 SHALL have port ID_EX_wb, output, 2, {RegWrite, MemtoReg}.
REQ-011 SHALL have port ID_EX_m, output, 3, {Branch, MemRead, MemWrite}.
REQ-012 SHALL have port ID_EX_ex, output, 4, {RegDst, ALUOp[1:0], ALUSrc}.
REQ-013 SHALL have ports ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext, all output, 32 bits.
REQ-014 SHALL have ports ID_EX_rt (instr[20:16]) and ID_EX_rd (instr[15:11]), both output, 5 bits.

Function
REQ-015 Decode from opcode instr[31:26]: 0x00 R-type -> wb=2'b10, m=3'b000, ex=4'b1100.
REQ-016 Decode 0x23 lw -> wb=2'b11, m=3'b010, ex=4'b0001.
REQ-017 Decode 0x2B sw -> wb=2'b00, m=3'b001, ex=4'b0001.
REQ-018 Decode 0x04 beq -> wb=2'b00, m=3'b100, ex=4'b0010.
REQ-019 Any other opcode, and instruction word 0x00000000 (nop): all control fields zero.
REQ-020 Sign extension: ID_EX_sign_ext = {{16{instr[15]}}, instr[15:0]}.
REQ-021 Register file: 32x32; reads combinational on rs=instr[25:21] and rt=instr[20:16].
REQ-022 Register file writes on the rising edge when MEM_WB_RegWrite=1.
REQ-023 Register 0 SHALL always read 0; writes to register 0 are ignored.
REQ-024 Read during write to the same nonzero index SHALL return MEM_WB_WriteData in the same cycle (internal bypass).
REQ-025 All ID_EX_* outputs are registered with one-cycle latency: values decoded in cycle N appear after edge N.
REQ-026 Hazard: ID_stall=1 (combinational) when ID_EX_m[1]=1, ID_EX_rt!=0, and ID_EX_rt equals instr rs or rt.
REQ-027 While ID_stall=1, the next edge SHALL load ID_EX_wb/m/ex with zero (bubble); data fields latch normally.
REQ-028 EX_MEM_PCSrc=1 SHALL zero ID_EX_wb/m/ex at the next edge.
REQ-029 Flush and stall together: bubble inserted once; ID_stall SHALL still follow REQ-026 combinationally.
REQ-030 Writeback and decode in the same cycle are both performed; the bypass per REQ-024 applies.

Reset
REQ-031 rst_n=0 SHALL immediately clear all ID_EX_* outputs and all 32 registers to 0, independent of clk.
REQ-032 ID_stall SHALL read 0 during reset, since it derives from the cleared ID_EX_m.
REQ-033 Reset asserted mid-operation discards any in-flight decode; the first edge after release latches current inputs.

Structure
REQ-034 Opcode constants, control field widths, and bit positions SHALL reside in a shared constants file used by every pipeline stage.
REQ-035 The register file SHALL be a sub-module named regfile, containing the bypass logic; decode, hazard, and latch logic stay in idecode.

Verification
REQ-036 Reset test: reset with regs prefilled -> every output 0; reading r5 returns 0.
REQ-037 R-type test: write r1=7 and r2=9 via writeback, then instr 0x00221820 -> after one edge: readdat1=7, readdat2=9, rd=3, wb=10, ex=1100.
REQ-038 lw test: instr 0x8C43FFFC -> sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001, rt=3.
REQ-039 Load-use test: lw with rt=3, then add with rs=3 -> ID_stall=1 for one cycle, next ID_EX controls all zero, ID_stall=0 after.
REQ-040 Bypass and r0 test: writeback r4=0xDEAD concurrent with decode reading r4 -> readdat=0xDEAD; writeback to r0 -> r0 still reads 0.
REQ-041 Flush test: EX_MEM_PCSrc=1 during a valid sw -> ID_EX_wb/m/ex=0 after the edge; npc still latched.

Source files
------------

// File: rtl/idecode_pkg.sv
// Shared pipeline constants: opcodes, control field widths and instruction bit positions.
// Every stage imports this package so field layouts stay consistent across the pipeline.
package idecode_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;

    // Position of MemRead inside the {Branch, MemRead, MemWrite} field
    localparam int M_MEMREAD_BIT = 1;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        if (instr != 32'h0) begin
            unique case (instr[OPC_HI:OPC_LO])
                OP_RTYPE: c = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
                OP_LW:    c = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
                OP_SW:    c = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
                OP_BEQ:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
                default:  c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/idecode_regfile.sv
// 32x32 register file: two combinational read ports with write-to-read bypass,
// one synchronous write port; register 0 is hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A write landing this cycle is forwarded so decode never sees stale data
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
        if (raddr1_i == 5'd0) rdata1_o = '0;
        if (raddr2_i == 5'd0) rdata2_o = '0;
    end

endmodule

// File: rtl/idecode.sv
// Instruction decode stage: control decode, register read, sign extension,
// load-use hazard detection and the ID/EX pipeline latch.
module idecode
    import idecode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_instr,
    input  logic [31:0] IF_ID_npc,
    input  logic        EX_MEM_PCSrc,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_WriteReg,
    input  logic [31:0] MEM_WB_WriteData,
    output logic        ID_stall,
    output logic [1:0]  ID_EX_wb,
    output logic [2:0]  ID_EX_m,
    output logic [3:0]  ID_EX_ex,
    output logic [31:0] ID_EX_npc,
    output logic [31:0] ID_EX_readdat1,
    output logic [31:0] ID_EX_readdat2,
    output logic [31:0] ID_EX_sign_ext,
    output logic [4:0]  ID_EX_rt,
    output logic [4:0]  ID_EX_rd
);

    logic [4:0]  rs, rt, rd;
    logic [31:0] rdat1, rdat2, sext;
    ctrl_t       ctrl_dec, ctrl_d, ctrl_q;
    logic [31:0] npc_q, rdat1_q, rdat2_q, sext_q;
    logic [4:0]  rt_q, rd_q;

    assign rs   = IF_ID_instr[RS_HI:RS_LO];
    assign rt   = IF_ID_instr[RT_HI:RT_LO];
    assign rd   = IF_ID_instr[RD_HI:RD_LO];
    assign sext = {{16{IF_ID_instr[IMM_HI]}}, IF_ID_instr[IMM_HI:0]};

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (MEM_WB_RegWrite),
        .waddr_i  (MEM_WB_WriteReg),
        .wdata_i  (MEM_WB_WriteData),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rdat1),
        .rdata2_o (rdat2)
    );

    // Load in EX whose destination is a source here must wait one cycle
    assign ID_stall = ctrl_q.m[M_MEMREAD_BIT] && (rt_q != 5'd0) &&
                      ((rt_q == rs) || (rt_q == rt));

    assign ctrl_dec = decode_ctrl(IF_ID_instr);

    always_comb begin
        ctrl_d = ctrl_dec;
        if (ID_stall || EX_MEM_PCSrc) ctrl_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            npc_q   <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
            sext_q  <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            npc_q   <= IF_ID_npc;
            rdat1_q <= rdat1;
            rdat2_q <= rdat2;
            sext_q  <= sext;
            rt_q    <= rt;
            rd_q    <= rd;
        end
    end

    assign ID_EX_wb       = ctrl_q.wb;
    assign ID_EX_m        = ctrl_q.m;
    assign ID_EX_ex       = ctrl_q.ex;
    assign ID_EX_npc      = npc_q;
    assign ID_EX_readdat1 = rdat1_q;
    assign ID_EX_readdat2 = rdat2_q;
    assign ID_EX_sign_ext = sext_q;
    assign ID_EX_rt       = rt_q;
    assign ID_EX_rd       = rd_q;

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: directed vector table, reset sequence and randomized
// traffic, all checked against a behavioural model of the decode stage.
module tb_idecode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF_ID_instr, IF_ID_npc;
    logic        EX_MEM_PCSrc, MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] MEM_WB_WriteData;
    logic        ID_stall;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext;
    logic [4:0]  ID_EX_rt, ID_EX_rd;

    always #5 clk = ~clk;

    idecode dut (
        .clk(clk), .rst_n(rst_n), .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc),
        .EX_MEM_PCSrc(EX_MEM_PCSrc), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_WriteReg(MEM_WB_WriteReg), .MEM_WB_WriteData(MEM_WB_WriteData),
        .ID_stall(ID_stall), .ID_EX_wb(ID_EX_wb), .ID_EX_m(ID_EX_m), .ID_EX_ex(ID_EX_ex),
        .ID_EX_npc(ID_EX_npc), .ID_EX_readdat1(ID_EX_readdat1), .ID_EX_readdat2(ID_EX_readdat2),
        .ID_EX_sign_ext(ID_EX_sign_ext), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, se;
        logic [4:0]  rt, rd;
    } idex_t;

    idex_t       mexp;
    logic [31:0] mregs [32];
    logic        last_stall;

    typedef struct {
        logic [31:0] instr, npc;
        logic        pcsrc, we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        stall;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] rd1, rd2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Control field meaning taken straight from the opcode table
    function automatic void ref_ctrl(input logic [31:0] ins, output logic [1:0] wb,
                                     output logic [2:0] m, output logic [3:0] ex);
        wb = 2'b00; m = 3'b000; ex = 4'b0000;
        if (ins == 32'h0) return;
        case (ins[31:26])
            6'h00: begin wb = 2'b10; m = 3'b000; ex = 4'b1100; end
            6'h23: begin wb = 2'b11; m = 3'b010; ex = 4'b0001; end
            6'h2B: begin wb = 2'b00; m = 3'b001; ex = 4'b0001; end
            6'h04: begin wb = 2'b00; m = 3'b100; ex = 4'b0010; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (MEM_WB_RegWrite && MEM_WB_WriteReg == idx) return MEM_WB_WriteData;
        return mregs[idx];
    endfunction

    task automatic model_reset();
        mexp = '{default: '0};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wb"},  {30'h0, ID_EX_wb},  {30'h0, mexp.wb});
        chk({tag, ".m"},   {29'h0, ID_EX_m},   {29'h0, mexp.m});
        chk({tag, ".ex"},  {28'h0, ID_EX_ex},  {28'h0, mexp.ex});
        chk({tag, ".npc"}, ID_EX_npc, mexp.npc);
        chk({tag, ".rd1"}, ID_EX_readdat1, mexp.rd1);
        chk({tag, ".rd2"}, ID_EX_readdat2, mexp.rd2);
        chk({tag, ".sext"}, ID_EX_sign_ext, mexp.se);
        chk({tag, ".rt"},  {27'h0, ID_EX_rt},  {27'h0, mexp.rt});
        chk({tag, ".rd"},  {27'h0, ID_EX_rd},  {27'h0, mexp.rd});
    endtask

    // One cycle: drive, check hazard, clock, then check the latched stage
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                        input logic pcsrc, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd);
        idex_t nxt;
        logic  exp_stall;
        IF_ID_instr = ins; IF_ID_npc = npc; EX_MEM_PCSrc = pcsrc;
        MEM_WB_RegWrite = we; MEM_WB_WriteReg = wr; MEM_WB_WriteData = wd;
        #1;
        exp_stall = mexp.m[1] && (mexp.rt != 0) && (mexp.rt == ins[25:21] || mexp.rt == ins[20:16]);
        last_stall = ID_stall;
        chk({tag, ".stall"}, {31'h0, ID_stall}, {31'h0, exp_stall});
        ref_ctrl(ins, nxt.wb, nxt.m, nxt.ex);
        if (exp_stall || pcsrc) begin nxt.wb = 0; nxt.m = 0; nxt.ex = 0; end
        nxt.npc = npc;
        nxt.rd1 = ref_read(ins[25:21]);
        nxt.rd2 = ref_read(ins[20:16]);
        nxt.se  = {{16{ins[15]}}, ins[15:0]};
        nxt.rt  = ins[20:16];
        nxt.rd  = ins[15:11];
        @(posedge clk);
        if (we && wr != 0) mregs[wr] = wd;
        mexp = nxt;
        #1;
        check_outputs(tag);
    endtask

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h00000000, 32'h1, 0, 1, 5'd1, 32'd7,     0, 2'b00, 3'b000, 4'b0000, 32'd0, 32'd0};
        vecs[1]  = '{32'h00221820, 32'h2, 0, 1, 5'd2, 32'd9,     0, 2'b10, 3'b000, 4'b1100, 32'd7, 32'd9};
        vecs[2]  = '{32'h8C43FFFC, 32'h3, 0, 0, 5'd0, 32'd0,     0, 2'b11, 3'b010, 4'b0001, 32'd9, 32'd0};
        vecs[3]  = '{32'h00611820, 32'h4, 0, 0, 5'd0, 32'd0,     1, 2'b00, 3'b000, 4'b0000, 32'd0, 32'd7};
        vecs[4]  = '{32'h00611820, 32'h4, 0, 0, 5'd0, 32'd0,     0, 2'b10, 3'b000, 4'b1100, 32'd0, 32'd7};
        vecs[5]  = '{32'h00852020, 32'h5, 0, 1, 5'd4, 32'hDEAD,  0, 2'b10, 3'b000, 4'b1100, 32'hDEAD, 32'd0};
        vecs[6]  = '{32'h00001020, 32'h6, 0, 1, 5'd0, 32'h1234,  0, 2'b10, 3'b000, 4'b1100, 32'd0, 32'd0};
        vecs[7]  = '{32'hAC430004, 32'h100, 1, 0, 5'd0, 32'd0,   0, 2'b00, 3'b000, 4'b0000, 32'd9, 32'd0};
        vecs[8]  = '{32'h10220003, 32'h8, 0, 0, 5'd0, 32'd0,     0, 2'b00, 3'b100, 4'b0010, 32'd7, 32'd9};
        vecs[9]  = '{32'h08000005, 32'h9, 0, 0, 5'd0, 32'd0,     0, 2'b00, 3'b000, 4'b0000, 32'd0, 32'd0};
        vecs[10] = '{32'h8C450000, 32'hA, 0, 0, 5'd0, 32'd0,     0, 2'b11, 3'b010, 4'b0001, 32'd9, 32'd0};
        vecs[11] = '{32'hAC450000, 32'hB, 1, 0, 5'd0, 32'd0,     1, 2'b00, 3'b000, 4'b0000, 32'd9, 32'd0};
        vecs[12] = '{32'hAC450000, 32'hB, 0, 0, 5'd0, 32'd0,     0, 2'b00, 3'b001, 4'b0001, 32'd9, 32'd0};

        IF_ID_instr = 0; IF_ID_npc = 0; EX_MEM_PCSrc = 0;
        MEM_WB_RegWrite = 0; MEM_WB_WriteReg = 0; MEM_WB_WriteData = 0;
        last_stall = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_outputs("por");
        chk("por.stall", {31'h0, ID_stall}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(t, vecs[i].instr, vecs[i].npc, vecs[i].pcsrc, vecs[i].we, vecs[i].wr, vecs[i].wd);
            chk({t, ".tstall"}, {31'h0, last_stall}, {31'h0, vecs[i].stall});
            chk({t, ".twb"}, {30'h0, ID_EX_wb}, {30'h0, vecs[i].wb});
            chk({t, ".tm"},  {29'h0, ID_EX_m},  {29'h0, vecs[i].m});
            chk({t, ".tex"}, {28'h0, ID_EX_ex}, {28'h0, vecs[i].ex});
            chk({t, ".trd1"}, ID_EX_readdat1, vecs[i].rd1);
            chk({t, ".trd2"}, ID_EX_readdat2, vecs[i].rd2);
        end
        chk("lw.sext", ID_EX_sign_ext, 32'h0);

        // Mid-cycle asynchronous reset with registers prefilled
        step("pre", 32'h8C43FFFC, 32'h40, 0, 1, 5'd5, 32'h55);
        chk("pre.sext", ID_EX_sign_ext, 32'hFFFFFFFC);
        IF_ID_instr = 32'h00A00000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        chk("rst.stall", {31'h0, ID_stall}, 32'h0);
        #3;
        rst_n = 1'b1;
        step("post", 32'h00A00000, 32'h50, 0, 0, 5'd0, 32'd0);
        chk("post.r5", ID_EX_readdat1, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            logic [31:0] sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'($urandom);
                default: op = 6'h23;
            endcase
            ins = $urandom;
            ins[31:26] = op;
            ins[25:21] = 5'($urandom_range(0, 6));
            ins[20:16] = 5'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) ins = 32'h0;
            if (last_stall) ins = IF_ID_instr;
            step("rnd", ins, $urandom, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 6)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
